sum_accum: RTL and testbench

//   Parametrised multi-operand unsigned adder: next generation of the registered summing adder.

---
 rtl/sum_accum.sv | 127 ++++++++++++
 tb/tb_sum_accum.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_accum.sv
// sum_accum: N-operand unsigned adder with optional accumulation,
// saturate or wrap at SW bits, behind a two-stage valid/ready pipeline.
module sum_accum #(
    parameter int W   = 8,
    parameter int N   = 4,
    parameter int SW  = 12,
    parameter int SAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*W-1:0]  ops,
    input  logic            cin,
    input  logic            acc_en,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SW-1:0]   sum,
    output logic            sum_zero,
    output logic            sum_ovf
);

    // Pre-sum width holds N*(2^W-1)+1 without loss.
    localparam int FW = W + $clog2(N) + 1;
    // Accumulate width leaves one spare bit above both operands.
    localparam int TW = ((FW > SW) ? FW : SW) + 1;

    // Stage 1 state: pre-sum, accumulate flag, valid.
    logic [FW-1:0] r_s1_psum;
    logic          r_s1_acc;
    logic          r_s1_valid;

    // Stage 2 state: the visible result registers.
    logic [SW-1:0] r_sum;
    logic          r_zero;
    logic          r_ovf;
    logic          r_out_valid;

    // Handshake and datapath wires.
    logic          w_s1_ld;
    logic          w_s2_ld;
    logic [FW-1:0] w_psum;
    logic [TW-1:0] w_base;
    logic [TW-1:0] w_t;
    logic          w_ovf;
    logic [SW-1:0] w_sum_nx;
    logic          w_zero_nx;

    // S2 advances when it is empty or its result is being taken.
    // S1 accepts when empty or draining into S2; in_valid never feeds
    // back into in_ready.
    always_comb begin
        w_s2_ld = r_s1_valid & (~r_out_valid | out_ready);
        in_ready = ~r_s1_valid | w_s2_ld;
        w_s1_ld = in_valid & in_ready;
    end

    // Sum all packed operands plus carry-in at full precision.
    always_comb begin
        w_psum = FW'(cin);
        for (int k = 0; k < N; k++) begin
            w_psum = w_psum + FW'(ops[k*W +: W]);
        end
    end

    // Stage 1 register: capture pre-sum and accumulate request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_psum  <= '0;
            r_s1_acc   <= 1'b0;
            r_s1_valid <= 1'b0;
        end else begin
            if (w_s1_ld) begin
                r_s1_psum <= w_psum;
                r_s1_acc  <= acc_en;
            end
            if (in_ready) begin
                r_s1_valid <= in_valid;
            end
        end
    end

    // The previous result always sits in r_sum when S2 loads, even if it
    // was stalled, so it is the correct accumulation base in stream order.
    always_comb begin
        w_base = r_s1_acc ? TW'(r_sum) : '0;
        w_t = TW'(r_s1_psum) + w_base;
    end

    // Detect overflow above SW bits, then clamp or wrap.
    always_comb begin
        w_ovf = |w_t[TW-1:SW];
        w_sum_nx = w_t[SW-1:0];
        if (w_ovf && (SAT != 0)) begin
            w_sum_nx = '1;
        end
        w_zero_nx = (w_sum_nx == '0);
    end

    // Stage 2 register: result, flags and output valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum       <= '0;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_s2_ld) begin
                r_sum  <= w_sum_nx;
                r_zero <= w_zero_nx;
                r_ovf  <= w_ovf;
            end
            if (~r_out_valid | out_ready) begin
                r_out_valid <= r_s1_valid;
            end
        end
    end

    // Outputs come straight from the stage 2 registers.
    always_comb begin
        out_valid = r_out_valid;
        sum       = r_sum;
        sum_zero  = r_zero;
        sum_ovf   = r_ovf;
    end

endmodule

// File: tb/tb_sum_accum.sv
// tb_sum_accum: directed checks for sum_accum, run with a saturating
// and a wrapping instance fed the same stream.
module tb_sum_accum;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] ops;
    logic        cin;
    logic        acc_en;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [11:0] sum;
    logic        sum_zero;
    logic        sum_ovf;

    logic        in_ready_w;
    logic        out_valid_w;
    logic [11:0] sum_w;
    logic        zero_w;
    logic        ovf_w;

    int n_chk;
    int n_pass;
    int n_out;
    bit rand_rdy;

    typedef struct {
        logic [11:0] s;
        logic        z;
        logic        o;
        logic [11:0] s0;
        logic        o0;
    } exp_t;

    exp_t expq[$];

    logic        prv_stall;
    logic [11:0] prv_sum;

    sum_accum #(.W(8), .N(4), .SW(12), .SAT(1)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .ops(ops), .cin(cin), .acc_en(acc_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .sum_zero(sum_zero), .sum_ovf(sum_ovf)
    );

    sum_accum #(.W(8), .N(4), .SW(12), .SAT(0)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_w),
        .ops(ops), .cin(cin), .acc_en(acc_en),
        .out_valid(out_valid_w), .out_ready(out_ready),
        .sum(sum_w), .sum_zero(zero_w), .sum_ovf(ovf_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one beat, wait for its transfer, queue its expectation.
    task automatic send(input logic [31:0] o, input logic c,
                        input logic a, input logic [11:0] es,
                        input logic eo, input logic [11:0] es0,
                        input logic eo0);
        int   n;
        logic rdy;
        exp_t e;
        ops = o;
        cin = c;
        acc_en = a;
        in_valid = 1'b1;
        n = 0;
        rdy = 1'b0;
        while (!rdy && n < 100) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            n++;
        end
        if (rdy) begin
            e.s = es;
            e.z = (es == 12'd0);
            e.o = eo;
            e.s0 = es0;
            e.o0 = eo0;
            expq.push_back(e);
        end else begin
            chk("send_timeout", 0, 1);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", expq.size(), 0);
    endtask

    // Output monitor: scoreboard compare and stall stability.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prv_stall = 1'b0;
        end else begin
            if (prv_stall && out_valid) begin
                chk("stable", sum, prv_sum);
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    e = expq.pop_front();
                    chk("sum", sum, e.s);
                    chk("zero", sum_zero, e.z);
                    chk("ovf", sum_ovf, e.o);
                    chk("sum_wrap", sum_w, e.s0);
                    chk("ovf_wrap", ovf_w, e.o0);
                    n_out++;
                end
            end
            prv_stall = out_valid && !out_ready;
            prv_sum = sum;
        end
    end

    // Random backpressure source for the accumulating stream.
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int          start;
        int          p;
        int          t;
        int          t0;
        int          tot;
        int          tot0;
        logic [31:0] o;
        logic        c;
        logic        a;
        logic        eo;
        logic        eo0;

        n_chk = 0;
        n_pass = 0;
        n_out = 0;
        rand_rdy = 1'b0;
        prv_stall = 1'b0;
        prv_sum = '0;
        rst_n = 1'b1;
        in_valid = 1'b0;
        ops = '0;
        cin = 1'b0;
        acc_en = 1'b0;
        out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_zero", sum_zero, 0);
        chk("rst_ovf", sum_ovf, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // All-ones operands plus carry, with latency check.
        send(32'hFFFF_FFFF, 1'b1, 1'b0, 12'd1021, 1'b0, 12'd1021, 1'b0);
        chk("lat_early", out_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_valid", out_valid, 1);
        chk("lat_sum", sum, 1021);
        wait_drain();

        // Back-to-back accumulation into saturation / wrap.
        send(32'hFFFF_FFFF, 1'b1, 1'b0, 12'd1021, 1'b0, 12'd1021, 1'b0);
        send(32'hFFFF_FFFF, 1'b1, 1'b1, 12'd2042, 1'b0, 12'd2042, 1'b0);
        send(32'hFFFF_FFFF, 1'b1, 1'b1, 12'd3063, 1'b0, 12'd3063, 1'b0);
        send(32'hFFFF_FFFF, 1'b1, 1'b1, 12'd4084, 1'b0, 12'd4084, 1'b0);
        send(32'hFFFF_FFFF, 1'b1, 1'b1, 12'd4095, 1'b1, 12'd1009, 1'b1);
        wait_drain();

        // Zero result, then accumulate a single one.
        send(32'h0000_0000, 1'b0, 1'b0, 12'd0, 1'b0, 12'd0, 1'b0);
        send(32'h0000_0001, 1'b0, 1'b1, 12'd1, 1'b0, 12'd1, 1'b0);
        wait_drain();

        // Backpressure: two beats fill the pipe and close in_ready.
        out_ready = 1'b0;
        send(32'd10, 1'b0, 1'b0, 12'd10, 1'b0, 12'd10, 1'b0);
        send(32'd20, 1'b0, 1'b0, 12'd20, 1'b0, 12'd20, 1'b0);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_head", sum, 10);
        @(posedge clk);
        #1;
        chk("bp_still_closed", in_ready, 0);
        out_ready = 1'b1;
        start = n_out;
        fork
            begin
                send(32'd30, 1'b0, 1'b0, 12'd30, 1'b0, 12'd30, 1'b0);
                send(32'd40, 1'b0, 1'b0, 12'd40, 1'b0, 12'd40, 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
            end
        join
        #1;
        chk("bp_no_gaps", n_out - start, 4);
        wait_drain();

        // Accumulating stream under random backpressure.
        rand_rdy = 1'b1;
        tot = 0;
        tot0 = 0;
        for (int i = 0; i < 14; i++) begin
            o = {8'(i * 17), 8'd200, 8'(i * 3), 8'd90};
            c = 1'(i % 2);
            a = (i != 0);
            p = int'(o[7:0]) + int'(o[15:8]) + int'(o[23:16])
                + int'(o[31:24]) + int'(c);
            t = (a ? tot : 0) + p;
            eo = (t > 4095);
            tot = eo ? 4095 : t;
            t0 = (a ? tot0 : 0) + p;
            eo0 = (t0 > 4095);
            tot0 = t0 % 4096;
            send(o, c, a, 12'(tot), eo, 12'(tot0), eo0);
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        wait_drain();
        chk("final_sat", sum, tot);
        chk("final_wrap", sum_w, tot0);

        // Reset with both stages full, then accumulate from zero.
        out_ready = 1'b0;
        send(32'd3, 1'b0, 1'b0, 12'd3, 1'b0, 12'd3, 1'b0);
        send(32'd4, 1'b0, 1'b0, 12'd4, 1'b0, 12'd4, 1'b0);
        chk("pre_rst_full", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_sum", sum, 0);
        chk("mid_rst_ready", in_ready, 1);
        expq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(32'd5, 1'b0, 1'b1, 12'd5, 1'b0, 12'd5, 1'b0);
        wait_drain();
        chk("post_rst_sum", sum, 5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
